// File: rtl/dispatch_arbiter_pkg.sv
// Shared sizing constants and types for the dispatch arbiter slice.
package core_pkg;

    localparam int DISP_WIDTH = 2;
    localparam int NUM_PIPES  = 2;
    localparam int RS_DEPTH   = 8;

    localparam int PIPE_W = (NUM_PIPES  > 1) ? $clog2(NUM_PIPES)  : 1;
    localparam int LANE_W = (DISP_WIDTH > 1) ? $clog2(DISP_WIDTH) : 1;
    localparam int CRED_W = $clog2(RS_DEPTH + 1);

    typedef logic [PIPE_W-1:0] pipe_id_t;
    typedef logic [LANE_W-1:0] lane_id_t;
    typedef logic [CRED_W-1:0] credit_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Increment that sticks at the top of the 16-bit range.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == CNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/dispatch_arbiter_if.sv
// Dispatch-side bundle: lane requests in, grants and RS allocations out.
interface dispatch_arbiter_if;
    import core_pkg::*;

    logic                                stall;
    logic                                flush;
    logic     [DISP_WIDTH-1:0]           req_valid;
    pipe_id_t [DISP_WIDTH-1:0]           req_pipe;
    logic     [NUM_PIPES-1:0]            credit_return;
    logic     [DISP_WIDTH-1:0]           grant;
    logic     [NUM_PIPES-1:0]            rs_alloc_valid;
    lane_id_t [NUM_PIPES-1:0]            rs_alloc_lane;
    credit_t  [NUM_PIPES-1:0]            credits;
    logic                                prio_ptr;
    logic     [15:0]                     conflict_cnt;
    logic                                credit_err;

    // Arbiter side.
    modport slave (
        input  stall, flush, req_valid, req_pipe, credit_return,
        output grant, rs_alloc_valid, rs_alloc_lane, credits,
               prio_ptr, conflict_cnt, credit_err
    );

    // Dispatch queue / backend side.
    modport master (
        output stall, flush, req_valid, req_pipe, credit_return,
        input  grant, rs_alloc_valid, rs_alloc_lane, credits,
               prio_ptr, conflict_cnt, credit_err
    );

endinterface

// File: rtl/rs_credit_counter.sv
// Free-entry counter for one reservation station. Allocation is only
// requested while the count is non-zero, so it never underflows; a return
// while already full is clamped and reported as an overflow.
module rs_credit_counter #(
    parameter int RS_DEPTH = core_pkg::RS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic             ret,
    output core_pkg::credit_t credits,
    output logic             nonzero,
    output logic             overflow
);
    import core_pkg::*;

    localparam credit_t FULL = credit_t'(RS_DEPTH);

    logic full;

    // Status flags derived from the registered count.
    always_comb begin
        full     = (credits == FULL);
        nonzero  = (credits != '0);
        overflow = ret & ~alloc & full;
    end

    // Count update: alloc and ret together cancel out.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= FULL;
        end else begin
            case ({alloc, ret})
                2'b10:   credits <= credits - credit_t'(1);
                2'b01:   if (!full) credits <= credits + credit_t'(1);
                default: credits <= credits;
            endcase
        end
    end

endmodule

// File: rtl/dispatch_arbiter.sv
// Two-lane dispatch arbiter: grants lane heads into execution pipes against
// per-pipe reservation-station credits, rotating priority on same-pipe
// conflicts. Grants are combinational from inputs and registered state.
// Parameters must match the widths fixed in core_pkg.
module dispatch_arbiter #(
    parameter int DISP_WIDTH = core_pkg::DISP_WIDTH,
    parameter int NUM_PIPES  = core_pkg::NUM_PIPES,
    parameter int RS_DEPTH   = core_pkg::RS_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    dispatch_arbiter_if.slave bus
);
    import core_pkg::*;

    logic    [DISP_WIDTH-1:0] lane_elig;
    logic    [DISP_WIDTH-1:0] grant;
    logic                     conflict;
    logic    [NUM_PIPES-1:0]  pipe_open;
    logic    [NUM_PIPES-1:0]  overflow;
    logic    [NUM_PIPES-1:0]  alloc_valid;
    lane_id_t [NUM_PIPES-1:0] alloc_lane;
    credit_t [NUM_PIPES-1:0]  credit_q;
    logic                     prio_ptr;
    logic    [15:0]           conflict_cnt;
    logic                     credit_err;

    // Lane eligibility and the two-lane grant decision.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lane_elig = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            lane_elig[i] = bus.req_valid[i] & pipe_open[bus.req_pipe[i]]
                         & ~bus.stall & ~bus.flush & ~rst;
        end
        conflict = lane_elig[0] & lane_elig[1]
                 & (bus.req_pipe[0] == bus.req_pipe[1]);
        grant = lane_elig;
        if (conflict) begin
            grant           = '0;
            grant[prio_ptr] = 1'b1;
        end
    end

    // Map granted lanes onto their target pipes (at most one per pipe).
    always_comb begin
        alloc_valid = '0;
        alloc_lane  = '0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            for (int i = 0; i < DISP_WIDTH; i++) begin
                if (grant[i] && bus.req_pipe[i] == pipe_id_t'(p)) begin
                    alloc_valid[p] = 1'b1;
                    alloc_lane[p]  = lane_id_t'(i);
                end
            end
        end
    end

    // One credit counter per reservation station.
    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_credit
        rs_credit_counter #(
            .RS_DEPTH (RS_DEPTH)
        ) u_counter (
            .clk      (clk),
            .rst      (rst),
            .alloc    (alloc_valid[p]),
            .ret      (bus.credit_return[p]),
            .credits  (credit_q[p]),
            .nonzero  (pipe_open[p]),
            .overflow (overflow[p])
        );
    end

    // Priority rotation, conflict statistics and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_ptr     <= 1'b0;
            conflict_cnt <= '0;
            credit_err   <= 1'b0;
        end else begin
            if (conflict) begin
                prio_ptr     <= ~prio_ptr;
                conflict_cnt <= sat_inc16(conflict_cnt);
            end
            if (|overflow) begin
                credit_err <= 1'b1;
            end
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.grant          = grant;
        bus.rs_alloc_valid = alloc_valid;
        bus.rs_alloc_lane  = alloc_lane;
        bus.credits        = credit_q;
        bus.prio_ptr       = prio_ptr;
        bus.conflict_cnt   = conflict_cnt;
        bus.credit_err     = credit_err;
    end

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Self-checking bench for dispatch_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural model of credits and priority.
module tb_dispatch_arbiter;

    logic clk;
    logic rst;

    dispatch_arbiter_if bus ();

    dispatch_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Model state.
    int m_cred [2];
    int m_prio;
    int m_cnt;
    int m_err;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, compare outputs against the model, then
    // advance the model to the state expected after the next rising edge.
    task automatic cyc(input logic r, input logic st, input logic fl,
                       input logic [1:0] v, input logic [1:0] pp,
                       input logic [1:0] ret);
        logic [1:0] elig;
        logic [1:0] exp_g;
        logic [1:0] exp_av;
        int         exp_lane [2];
        int         is_conflict;
        int         c;

        @(negedge clk);
        rst               = r;
        bus.stall         = st;
        bus.flush         = fl;
        bus.req_valid     = v;
        bus.req_pipe[0]   = pp[0];
        bus.req_pipe[1]   = pp[1];
        bus.credit_return = ret;
        #1;

        for (int i = 0; i < 2; i++)
            elig[i] = v[i] && (m_cred[pp[i]] > 0) && !st && !fl && !r;
        is_conflict = (elig == 2'b11) && (pp[0] == pp[1]);
        exp_g = is_conflict ? (2'b01 << m_prio) : elig;
        exp_av = 2'b00;
        exp_lane[0] = 0;
        exp_lane[1] = 0;
        for (int i = 0; i < 2; i++) begin
            if (exp_g[i]) begin
                exp_av[pp[i]]   = 1'b1;
                exp_lane[pp[i]] = i;
            end
        end

        check("credits0", 32'(bus.credits[0]), 32'(m_cred[0]));
        check("credits1", 32'(bus.credits[1]), 32'(m_cred[1]));
        check("prio_ptr", 32'(bus.prio_ptr), 32'(m_prio));
        check("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_cnt));
        check("credit_err", 32'(bus.credit_err), 32'(m_err));
        check("grant", 32'(bus.grant), 32'(exp_g));
        check("rs_alloc_valid", 32'(bus.rs_alloc_valid), 32'(exp_av));
        for (int p = 0; p < 2; p++)
            if (exp_av[p])
                check($sformatf("rs_alloc_lane%0d", p),
                      32'(bus.rs_alloc_lane[p]), 32'(exp_lane[p]));

        if (r) begin
            m_cred[0] = 8;
            m_cred[1] = 8;
            m_prio    = 0;
            m_cnt     = 0;
            m_err     = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                c = m_cred[p] - int'(exp_av[p]) + int'(ret[p]);
                if (c > 8) begin
                    c     = 8;
                    m_err = 1;
                end
                m_cred[p] = c;
            end
            if (is_conflict) begin
                m_prio = 1 - m_prio;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b11);
    endtask

    initial begin
        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.req_valid     = 2'b00;
        bus.req_pipe[0]   = 1'b0;
        bus.req_pipe[1]   = 1'b0;
        bus.credit_return = 2'b00;
        m_cred[0] = 8;
        m_cred[1] = 8;
        m_prio = 0;
        m_cnt  = 0;
        m_err  = 0;
        @(posedge clk);

        // Reset cycle with active requests: nothing granted, reset state.
        do_reset();
        check("rst_grant", 32'(bus.grant), 32'd0);

        // Both lanes, different pipes: dual grant, credits 7/7 after.
        cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 2'b00);
        check("dual_grant", 32'(bus.grant), 32'd3);
        check("dual_alloc", 32'(bus.rs_alloc_valid), 32'd3);
        idle();
        check("dual_cred0", 32'(bus.credits[0]), 32'd7);
        check("dual_cred1", 32'(bus.credits[1]), 32'd7);

        // Same-pipe conflict for 4 cycles: alternating grants.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
            check("conf_grant", 32'(bus.grant), (k % 2) ? 32'd2 : 32'd1);
        end
        idle();
        check("conf_cnt", 32'(bus.conflict_cnt), 32'd4);

        // Drain pipe 1, blocked, then unblocked one cycle after a return.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00);
            check("drain_grant", 32'(bus.grant), 32'd1);
        end
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00);
        check("empty_grant", 32'(bus.grant), 32'd0);
        check("empty_cred1", 32'(bus.credits[1]), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b10);
        check("ret_same_cycle", 32'(bus.grant), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00);
        check("ret_next_cycle", 32'(bus.grant), 32'd1);

        // Simultaneous alloc and return at credits 3.
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01);
        check("bal_before", 32'(bus.credits[0]), 32'd3);
        idle();
        check("bal_after", 32'(bus.credits[0]), 32'd3);

        // Return into a full pipe: clamp and sticky error until reset.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10);
        idle();
        check("ovf_cred1", 32'(bus.credits[1]), 32'd8);
        check("ovf_err", 32'(bus.credit_err), 32'd1);
        for (int k = 0; k < 3; k++) idle();
        check("ovf_sticky", 32'(bus.credit_err), 32'd1);
        do_reset();
        idle();
        check("ovf_cleared", 32'(bus.credit_err), 32'd0);

        // Stall with a same-pipe conflict: no grant, no rotation.
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
        check("stall_grant", 32'(bus.grant), 32'd0);
        idle();
        check("stall_prio", 32'(bus.prio_ptr), 32'd0);
        check("stall_cnt", 32'(bus.conflict_cnt), 32'd0);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(199) == 0),
                ($urandom_range(9) == 0),
                ($urandom_range(15) == 0),
                2'($urandom_range(3)),
                2'($urandom_range(3)),
                {($urandom_range(2) == 0), ($urandom_range(2) == 0)});
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
